mul_sequencer: RTL and testbench
================================

// Module: mul_sequencer
// PURPOSE
//  Multi-cycle controller for the MUL operation (ALU control code 4'd8) in the EX stage.
//  Runs a radix-2 shift-add multiply over several cycles.
//  Stalls the pipeline until the product is ready, then presents the low WIDTH bits (RV32 MUL).
//  Sits beside the ALU; EX result mux selects mul_result when alu_control==MUL_OP.
// PARAMETERS
//  WIDTH    32   operand/result width; iteration count.
//  CNT_W    6    counter width; must satisfy 2**CNT_W > WIDTH.
// PORTS
//  clk          in   1      single clock, all state on rising edge.
//  rst          in   1      synchronous, active-high reset.
//  alu_control  in   4      ALU control code of the instruction in EX.
//  ex_valid     in   1      EX holds a valid, non-bubble instruction.
//  flush        in   1      squash EX instruction (branch/exception); aborts multiply.
//  op_a         in   WIDTH  multiplicand (rs1).
//  op_b         in   WIDTH  multiplier (rs2).
//  stall        out  1      combinational; hold IF/ID/EX while high.
//  mul_done     out  1      registered; one-cycle pulse, mul_result valid.
//  mul_result   out  WIDTH  registered; low WIDTH bits of op_a*op_b.
//  busy         out  1      registered; state != IDLE.
// BEHAVIOUR
//  - mul_req = ex_valid & (alu_control==MUL_OP) & ~flush.
//  - States: IDLE, RUN, DONE (2-bit encoding).
//    IDLE -> RUN  on mul_req: latch mcand<=op_a, mplier<=op_b, acc<=0, cnt<=0.
//    RUN  -> RUN  each cycle: if mplier[0], acc<=acc+mcand; mcand<<=1; mplier>>=1; cnt++.
//    RUN  -> DONE after the iteration with cnt==WIDTH-1: mul_result<=final acc, mul_done<=1.
//    DONE -> IDLE unconditionally; mul_done drops.
//  - stall = (IDLE & mul_req) | RUN. Low in DONE, so the pipeline advances on the DONE edge.
//  - Latency (feature off): stall high for WIDTH+1 cycles; mul_done in cycle WIDTH+1 after request.
//  - Arithmetic: acc, mcand are WIDTH bits; carries beyond bit WIDTH-1 are discarded.
//    Signed and unsigned operands give the same low half; no sign handling.
//  - Back-to-back MUL: DONE->IDLE costs one cycle. The next mul_req is sampled in IDLE, so no request is lost.
//  - flush in RUN: next state IDLE, acc discarded, no mul_done, stall=0 that cycle.
//    flush in DONE: ignored; result already committed.
//  - Non-MUL codes never leave IDLE; stall=0.
//  - Operand changes during RUN are ignored; operands are latched.
//  - rst (any state): state=IDLE, cnt=0, acc=0, mul_result=0, mul_done=0, busy=0; stall=0 while rst high.
//  - op_b==0 completes with full latency (feature off) and result 0.
// CONFIGURATION
//  MUL_EARLY_TERM_EN defined:
//    - RUN -> DONE also when the shifted-out mplier==0 after an iteration; result is identical.
//    - Latency becomes (index of op_b MSB set)+2 cycles of stall.
//    - op_b==0 -> one RUN cycle then DONE.
//  MUL_EARLY_TERM_EN undefined: fixed WIDTH iterations; the early-exit compare is absent from the netlist.
// STRUCTURE
//  - Shared package/header alu_defs: ALU control codes (AND_OP..MUL_OP, MUL_OP=4'd8), ALUOp codes, mul state encoding.
//  - One sub-module, mul_shift_add_step: combinational single iteration
//    (acc, mcand, mplier) -> next values.
//  - FSM, counter and result register stay in mul_sequencer.
// TESTING
//  1. rst held 2 cycles mid-RUN -> busy=0, mul_done=0, mul_result=0, stall=0 the cycle after release.
//  2. op_a=7, op_b=6, MUL: stall high 33 cycles (WIDTH=32) -> mul_done pulse, mul_result=42.
//  3. op_a=32'hFFFFFFFF, op_b=32'hFFFFFFFF -> mul_result=32'h00000001; op_a=-3, op_b=5 -> 32'hFFFFFFF1.
//  4. Two consecutive MULs (3*4, then 5*5) -> results 12 and 25, one IDLE cycle between; no lost request.
//  5. flush at RUN cycle 10 -> no mul_done, stall low that cycle, busy=0 next cycle; subsequent MUL 2*3=6 correct.
//  6. alu_control=ADD_OP with ex_valid=1 -> stall=0, busy stays 0.
//     With MUL_EARLY_TERM_EN: op_b=1 -> stall 2 cycles, result=op_a; op_b=0 -> result 0.

Source files
------------

// File: rtl/alu_defs.sv
// alu_defs: shared ALU definitions for the EX stage.
//   - ALU control codes (4 bits) driven by the ALU decoder; MUL_OP selects
//     the multi-cycle multiply path (mul_sequencer).
//   - ALUOp codes (2 bits) from the main decoder.
//   - State encoding of the multiply sequencer.
package alu_defs;

    // ALU control codes
    localparam logic [3:0] AND_OP = 4'd0;
    localparam logic [3:0] OR_OP  = 4'd1;
    localparam logic [3:0] ADD_OP = 4'd2;
    localparam logic [3:0] XOR_OP = 4'd3;
    localparam logic [3:0] SLL_OP = 4'd4;
    localparam logic [3:0] SRL_OP = 4'd5;
    localparam logic [3:0] SUB_OP = 4'd6;
    localparam logic [3:0] SLT_OP = 4'd7;
    localparam logic [3:0] MUL_OP = 4'd8;

    // ALUOp codes from the main decoder
    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    // Multiply sequencer states
    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_RUN  = 2'd1,
        MS_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mul_shift_add_step.sv
// mul_shift_add_step: one combinational radix-2 shift-add iteration.
// Ports:
//   acc, mcand, mplier        in   WIDTH  current partial product / operands
//   acc_n, mcand_n, mplier_n  out  WIDTH  values after this iteration
// Carries above bit WIDTH-1 are dropped, so only the low half is formed.
module mul_shift_add_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    output logic [WIDTH-1:0] acc_n,
    output logic [WIDTH-1:0] mcand_n,
    output logic [WIDTH-1:0] mplier_n
);

    assign acc_n    = mplier[0] ? (acc + mcand) : acc;
    assign mcand_n  = mcand << 1;
    assign mplier_n = mplier >> 1;

endmodule

// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle MUL controller for the EX stage.
// Runs a radix-2 shift-add multiply and stalls the pipeline until the low
// WIDTH bits of op_a*op_b are ready.
// Ports:
//   clk, rst      in   clock, synchronous active-high reset
//   alu_control   in   4      ALU control code of the EX instruction
//   ex_valid      in   1      EX holds a valid instruction
//   flush         in   1      squash EX instruction, aborts a multiply
//   op_a, op_b    in   WIDTH  multiplicand / multiplier
//   stall         out  1      combinational pipeline hold
//   mul_done      out  1      one-cycle pulse, mul_result valid
//   mul_result    out  WIDTH  low half of the product
//   busy          out  1      sequencer not idle
// Build option: MUL_EARLY_TERM_EN -- finish as soon as the remaining
// multiplier bits are all zero.
module mul_sequencer
    import alu_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       alu_control,
    input  logic             ex_valid,
    input  logic             flush,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             stall,
    output logic             mul_done,
    output logic [WIDTH-1:0] mul_result,
    output logic             busy
);

    mul_state_e       state, state_n;
    logic [WIDTH-1:0] acc, mcand, mplier;
    logic [WIDTH-1:0] acc_n, mcand_n, mplier_n;
    logic [CNT_W-1:0] cnt;
    logic             mul_req, last, load, step, finish;

    assign mul_req = ex_valid & (alu_control == MUL_OP) & ~flush;

    mul_shift_add_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .mcand    (mcand),
        .mplier   (mplier),
        .acc_n    (acc_n),
        .mcand_n  (mcand_n),
        .mplier_n (mplier_n)
    );

`ifdef MUL_EARLY_TERM_EN
    assign last = (cnt == CNT_W'(WIDTH-1)) | (mplier_n == '0);
`else
    assign last = (cnt == CNT_W'(WIDTH-1));
`endif

    always_comb begin
        state_n = state;
        stall   = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state)
            MS_IDLE: begin
                if (mul_req) begin
                    state_n = MS_RUN;
                    stall   = 1'b1;
                    load    = 1'b1;
                end
            end
            MS_RUN: begin
                // flush releases the pipeline in the same cycle
                if (flush) begin
                    state_n = MS_IDLE;
                end else begin
                    stall = 1'b1;
                    step  = 1'b1;
                    if (last) begin
                        state_n = MS_DONE;
                        finish  = 1'b1;
                    end
                end
            end
            MS_DONE: state_n = MS_IDLE;
            default: state_n = MS_IDLE;
        endcase
        if (rst) stall = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= MS_IDLE;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            cnt        <= '0;
            mul_result <= '0;
            mul_done   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state    <= state_n;
            busy     <= (state_n != MS_IDLE);
            mul_done <= finish;
            if (load) begin
                mcand  <= op_a;
                mplier <= op_b;
                acc    <= '0;
                cnt    <= '0;
            end else if (step) begin
                acc    <= acc_n;
                mcand  <= mcand_n;
                mplier <= mplier_n;
                cnt    <= cnt + CNT_W'(1);
            end
            // result taken from the final iteration's sum, not the stale acc
            if (finish) mul_result <= acc_n;
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed self-checking bench for mul_sequencer (WIDTH=32).
module tb_mul_sequencer;
    import alu_defs::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  alu_control;
    logic        ex_valid;
    logic        flush;
    logic [31:0] op_a, op_b;
    logic        stall, mul_done, busy;
    logic [31:0] mul_result;

    int n_chk = 0;
    int n_err = 0;

    mul_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_control (alu_control),
        .ex_valid    (ex_valid),
        .flush       (flush),
        .op_a        (op_a),
        .op_b        (op_b),
        .stall       (stall),
        .mul_done    (mul_done),
        .mul_result  (mul_result),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // expected stall cycles for a given multiplier
    function automatic int exp_lat(input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
        int msb = 0;
        for (int i = 0; i < 32; i++) if (b[i]) msb = i;
        return msb + 2;
`else
        return (b == 32'd0) ? 33 : 33;
`endif
    endfunction

    // Issue a MUL at the current (post-negedge) point, count stall cycles
    // until the mul_done cycle, then drop ex_valid (pipeline advances).
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           output int stalls, output int first_stall,
                           output logic [31:0] res, output logic seen,
                           output logic idle_busy);
        stalls = 0; first_stall = -1; res = '0; seen = 1'b0; idle_busy = 1'b1;
        alu_control = MUL_OP; ex_valid = 1'b1; op_a = a; op_b = b;
        #1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (mul_done && stalls > 0) begin
                seen = 1'b1;
                res  = mul_result;
                break;
            end
            if (stall) begin
                if (first_stall < 0) begin
                    first_stall = cyc;
                    idle_busy   = busy;
                end
                stalls++;
            end
            @(negedge clk);
        end
        ex_valid = 1'b0;
    endtask

    int          st, fs, cnt_done;
    logic [31:0] r;
    logic        sd, ib;

    initial begin
        rst = 1'b1; alu_control = ADD_OP; ex_valid = 1'b0; flush = 1'b0;
        op_a = '0; op_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("init_busy", {31'd0, busy}, 32'd0);
        chk("init_done", {31'd0, mul_done}, 32'd0);
        chk("init_res", mul_result, 32'd0);

        // 7*6
        run_mul(32'd7, 32'd6, st, fs, r, sd, ib);
        chk("m76_seen", {31'd0, sd}, 32'd1);
        chk("m76_stall", st, exp_lat(32'd6));
        chk("m76_res", r, 32'd42);
        @(negedge clk);
        chk("m76_pulse", {31'd0, mul_done}, 32'd0);
        chk("m76_idle", {31'd0, busy}, 32'd0);

        // all ones and signed operands
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, st, fs, r, sd, ib);
        chk("mff_seen", {31'd0, sd}, 32'd1);
        chk("mff_res", r, 32'h00000001);
        @(negedge clk);
        run_mul(32'hFFFFFFFD, 32'd5, st, fs, r, sd, ib);
        chk("mneg_res", r, 32'hFFFFFFF1);
        chk("mneg_stall", st, exp_lat(32'd5));
        @(negedge clk);

        // back-to-back: second request driven in the DONE cycle
        run_mul(32'd3, 32'd4, st, fs, r, sd, ib);
        chk("bb1_res", r, 32'd12);
        run_mul(32'd5, 32'd5, st, fs, r, sd, ib);
        chk("bb2_seen", {31'd0, sd}, 32'd1);
        chk("bb2_res", r, 32'd25);
        chk("bb2_gap", fs, 32'd1);
        chk("bb2_idle", {31'd0, ib}, 32'd0);
        chk("bb2_stall", st, exp_lat(32'd5));
        @(negedge clk);

        // flush at RUN cycle 10 (needs a long multiplier to still be running)
        alu_control = MUL_OP; ex_valid = 1'b1; op_a = 32'd9; op_b = 32'h80000009;
        repeat (11) @(negedge clk);
        chk("fl_busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        #1;
        chk("fl_stall", {31'd0, stall}, 32'd0);
        chk("fl_done", {31'd0, mul_done}, 32'd0);
        @(negedge clk);
        flush = 1'b0; ex_valid = 1'b0;
        #1;
        chk("fl_busy_after", {31'd0, busy}, 32'd0);
        cnt_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mul_done) cnt_done++;
        end
        chk("fl_no_done", cnt_done, 32'd0);
        run_mul(32'd2, 32'd3, st, fs, r, sd, ib);
        chk("fl_next_res", r, 32'd6);
        @(negedge clk);

        // non-MUL code never starts the sequencer
        alu_control = ADD_OP; ex_valid = 1'b1; op_a = 32'd7; op_b = 32'd6;
        #1;
        chk("add_stall", {31'd0, stall}, 32'd0);
        repeat (3) @(negedge clk);
        chk("add_busy", {31'd0, busy}, 32'd0);
        chk("add_stall2", {31'd0, stall}, 32'd0);
        ex_valid = 1'b0;
        @(negedge clk);

        // op_b == 0
        run_mul(32'd1234, 32'd0, st, fs, r, sd, ib);
        chk("z_res", r, 32'd0);
        chk("z_stall", st, exp_lat(32'd0));
        @(negedge clk);
`ifdef MUL_EARLY_TERM_EN
        run_mul(32'hDEADBEEF, 32'd1, st, fs, r, sd, ib);
        chk("et1_res", r, 32'hDEADBEEF);
        chk("et1_stall", st, 32'd2);
        @(negedge clk);
`endif

        // reset held 2 cycles mid-RUN
        alu_control = MUL_OP; ex_valid = 1'b1; op_a = 32'd11; op_b = 32'hFFFF0000;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rr_stall_in_rst", {31'd0, stall}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0; ex_valid = 1'b0;
        @(negedge clk);
        chk("rr_busy", {31'd0, busy}, 32'd0);
        chk("rr_done", {31'd0, mul_done}, 32'd0);
        chk("rr_res", mul_result, 32'd0);
        chk("rr_stall", {31'd0, stall}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
